// File: rtl/full_adder.sv
// ---------------------------------------------------------------------------
// full_adder -- single-bit full adder, one stage of the ripple-carry chain.
//
// Ports
//   a   in   1  addend bit
//   b   in   1  addend bit
//   ci  in   1  carry in from the previous (less significant) stage
//   s   out  1  sum bit
//   co  out  1  carry out to the next (more significant) stage
// ---------------------------------------------------------------------------
module full_adder (
   input  logic a,
   input  logic b,
   input  logic ci,
   output logic s,
   output logic co
);

   logic p;

   // Propagate term is shared by sum and carry.
   assign p  = a ^ b;
   assign s  = p ^ ci;
   assign co = (a & b) | (ci & p);

endmodule

// File: rtl/four_bit_rca.sv
// ---------------------------------------------------------------------------
// four_bit_rca -- 4-bit ripple-carry adder with registered outputs.
//
// Computes {Cout, Sum} = A + B + Cin through four chained full_adder stages
// and registers the result on the rising clock edge (1-cycle latency, one
// operation per cycle, no handshake). Inputs are not registered; the only
// state is the 5 output flops.
//
// Ports
//   clk    in   1  rising-edge clock
//   rst_n  in   1  synchronous active-low reset, clears Sum and Cout
//   A      in   4  unsigned addend
//   B      in   4  unsigned addend
//   Cin    in   1  carry-in at bit 0
//   Sum    out  4  registered sum, modulo 16
//   Cout   out  1  registered carry-out of bit 3
// ---------------------------------------------------------------------------
module four_bit_rca (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [3:0] A,
   input  logic [3:0] B,
   input  logic       Cin,
   output logic [3:0] Sum,
   output logic       Cout
);

   localparam int WIDTH = 4;

   // carry[i] feeds stage i; carry[WIDTH] is the final carry-out.
   logic [WIDTH:0]   carry;
   logic [WIDTH-1:0] s;

   assign carry[0] = Cin;

   for (genvar i = 0; i < WIDTH; i++) begin : g_stage
      full_adder u_fa (
         .a  (A[i]),
         .b  (B[i]),
         .ci (carry[i]),
         .s  (s[i]),
         .co (carry[i+1])
      );
   end

   // Reset wins over whatever is on the inputs at the same edge.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         Sum  <= '0;
         Cout <= 1'b0;
      end else begin
         Sum  <= s;
         Cout <= carry[WIDTH];
      end
   end

endmodule

// File: tb/tb_four_bit_rca.sv
// ---------------------------------------------------------------------------
// tb_four_bit_rca -- self-checking bench for four_bit_rca.
// Reference model: plain integer addition of A+B+Cin, split into sum mod 16
// and carry (>= 16). Each step drives inputs, waits one edge, checks the
// registered result, then scrambles the inputs mid-cycle and checks that the
// outputs hold.
// ---------------------------------------------------------------------------
module tb_four_bit_rca;

   logic       clk;
   logic       rst_n;
   logic [3:0] A;
   logic [3:0] B;
   logic       Cin;
   logic [3:0] Sum;
   logic       Cout;

   int checks = 0;
   int errors = 0;

   four_bit_rca dut (
      .clk   (clk),
      .rst_n (rst_n),
      .A     (A),
      .B     (B),
      .Cin   (Cin),
      .Sum   (Sum),
      .Cout  (Cout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step(input logic r, input logic [3:0] a, input logic [3:0] b,
                       input logic c, input string tag);
      int         tot;
      logic [3:0] exp_sum;
      logic       exp_cout;
      rst_n = r;
      A     = a;
      B     = b;
      Cin   = c;
      @(posedge clk);
      #1;
      tot      = int'(a) + int'(b) + int'(c);
      exp_sum  = r ? 4'(tot % 16) : 4'd0;
      exp_cout = r ? (tot >= 16) : 1'b0;
      checks++;
      assert (Sum === exp_sum && Cout === exp_cout)
      else begin
         errors++;
         $error("FAIL %s a=%0d b=%0d cin=%0d rst_n=%0b: got sum=%0d cout=%0b, expected sum=%0d cout=%0b",
                tag, a, b, c, r, Sum, Cout, exp_sum, exp_cout);
      end
      // Outputs must not follow input changes between edges.
      A   = 4'($urandom);
      B   = 4'($urandom);
      Cin = 1'($urandom);
      #2;
      checks++;
      assert (Sum === exp_sum && Cout === exp_cout)
      else begin
         errors++;
         $error("FAIL %s_hold: got sum=%0d cout=%0b, expected held sum=%0d cout=%0b",
                tag, Sum, Cout, exp_sum, exp_cout);
      end
   endtask

   initial begin
      int order [512];
      int tmp;
      int j;

      rst_n = 1'b0;
      A     = 4'd0;
      B     = 4'd0;
      Cin   = 1'b0;
      #2;

      // Reset held two cycles with non-zero operands.
      step(1'b0, 4'd9, 4'd7, 1'b1, "reset0");
      step(1'b0, 4'd9, 4'd7, 1'b1, "reset1");

      // A sweep with B=0, Cin=0: Sum follows A one cycle later.
      for (int a = 0; a < 16; a++) step(1'b1, 4'(a), 4'd0, 1'b0, "sweep");

      // Wrap and maximum cases.
      step(1'b1, 4'd15, 4'd1,  1'b0, "wrap");
      step(1'b1, 4'd15, 4'd15, 1'b1, "max");

      // Carry ripple through the chain.
      step(1'b1, 4'b0111, 4'b0001, 1'b0, "ripple3");
      step(1'b1, 4'b1000, 4'b1000, 1'b1, "ripple_out");
      step(1'b1, 4'b1111, 4'b0000, 1'b1, "ripple_all");

      // Exhaustive in shuffled order, with a one-cycle reset pulse mid-stream.
      for (int i = 0; i < 512; i++) order[i] = i;
      for (int i = 511; i > 0; i--) begin
         j        = int'($urandom_range(i, 0));
         tmp      = order[i];
         order[i] = order[j];
         order[j] = tmp;
      end
      for (int i = 0; i < 512; i++) begin
         if (i == 200)
            step(1'b0, 4'(order[i] >> 5), 4'(order[i] >> 1), 1'(order[i]), "midreset");
         step(1'b1, 4'(order[i] >> 5), 4'(order[i] >> 1), 1'(order[i]), "exhaustive");
      end

      // Random back-to-back traffic with occasional resets.
      for (int i = 0; i < 64; i++)
         step(($urandom_range(15, 0) != 0), 4'($urandom), 4'($urandom), 1'($urandom), "random");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
